// File: rtl/fb_clk_pkg.sv
// Shared types and helpers for the fabric clock-enable generator.
// Holds the settle FSM state encoding and counter-width helper.
package fb_clk_pkg;

  typedef enum logic {
    SETTLE = 1'b0,
    RUN    = 1'b1
  } state_t;

  localparam int DIV_W_DEF = 8;

  // Width needed to count from 0 up to cycles-1 (never narrower than 1 bit).
  function automatic int settle_cnt_w(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/fb_clken_ch.sv
// One enable channel: shadow/active ratio registers, down-counter and strobe.
// Ratios 0 and 1 both yield a strobe on every cycle.
module fb_clken_ch
  import fb_clk_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             fclk,
  input  logic             rst,
  input  logic             run,
  input  logic             align,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             ce
);

  localparam logic [DIV_W-1:0] DEF_RATIO = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ZERO      = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

  logic [DIV_W-1:0] shadow_r;
  logic [DIV_W-1:0] active_r;
  logic [DIV_W-1:0] cnt_r;
  logic             ce_r;
  logic [DIV_W-1:0] shadow_nxt_s;
  logic [DIV_W-1:0] reload_s;
  logic             strobe_s;

  // A load arriving on a strobe edge already governs the period that strobe starts.
  always_comb begin
    shadow_nxt_s = shadow_r;
    reload_s     = ZERO;
    strobe_s     = 1'b0;
    if (load) begin
      shadow_nxt_s = div;
    end else begin
      shadow_nxt_s = shadow_r;
    end
    if (shadow_nxt_s == ZERO) begin
      reload_s = ZERO;
    end else begin
      reload_s = shadow_nxt_s - ONE;
    end
    strobe_s = run && !align && ((cnt_r == ZERO) || (active_r <= ONE));
  end

  // Ratio registers, period counter and registered strobe.
  always_ff @(posedge fclk) begin
    if (rst) begin
      shadow_r <= DEF_RATIO;
      active_r <= DEF_RATIO;
      cnt_r    <= ZERO;
      ce_r     <= 1'b0;
    end else begin
      shadow_r <= shadow_nxt_s;
      if (align) begin
        cnt_r <= ZERO;
        ce_r  <= 1'b0;
      end else if (strobe_s) begin
        cnt_r    <= reload_s;
        active_r <= shadow_nxt_s;
        ce_r     <= 1'b1;
      end else begin
        ce_r <= 1'b0;
        if (run && (cnt_r != ZERO)) begin
          cnt_r <= cnt_r - ONE;
        end
      end
    end
  end

  assign ce = ce_r;

endmodule

// File: rtl/fb_clken_gen.sv
// Clock-enable generator: settle FSM, ready flag and NUM_CH divide-by-D channels.
// All channels leave SETTLE with zeroed counters, so their first strobes coincide.
module fb_clken_gen
  import fb_clk_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int DIV_W         = DIV_W_DEF,
  parameter int SETTLE_CYCLES = 16,
  parameter int DEFAULT_DIV   = 4
) (
  input  logic                    fclk,
  input  logic                    rst,
  input  logic [NUM_CH*DIV_W-1:0] div_in,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic                    align,
  output logic [NUM_CH-1:0]       ce_out,
  output logic                    ready
);

  localparam int            SW          = settle_cnt_w(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  state_t        state_r;
  state_t        state_nxt_s;
  logic [SW-1:0] settle_cnt_r;
  logic [SW-1:0] settle_cnt_nxt_s;
  logic          ready_r;
  logic          run_s;
  logic          align_run_s;

  // Settle sequencing: count out the interval, then stay in RUN until reset.
  always_comb begin
    state_nxt_s      = state_r;
    settle_cnt_nxt_s = settle_cnt_r;
    case (state_r)
      SETTLE: begin
        if (settle_cnt_r == SETTLE_LAST) begin
          state_nxt_s = RUN;
        end else begin
          settle_cnt_nxt_s = settle_cnt_r + SW'(1);
        end
      end
      RUN: begin
        state_nxt_s = RUN;
      end
      default: begin
        state_nxt_s      = SETTLE;
        settle_cnt_nxt_s = {SW{1'b0}};
      end
    endcase
  end

  // FSM state, settle counter and ready flag.
  always_ff @(posedge fclk) begin
    if (rst) begin
      state_r      <= SETTLE;
      settle_cnt_r <= {SW{1'b0}};
      ready_r      <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      settle_cnt_r <= settle_cnt_nxt_s;
      ready_r      <= (state_r == RUN);
    end
  end

  assign run_s       = (state_r == RUN);
  assign align_run_s = align & run_s;
  assign ready       = ready_r;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    fb_clken_ch #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .fclk  (fclk),
      .rst   (rst),
      .run   (run_s),
      .align (align_run_s),
      .load  (div_load[i]),
      .div   (div_in[i*DIV_W +: DIV_W]),
      .ce    (ce_out[i])
    );
  end

endmodule

// File: tb/tb_fb_clken_gen.sv
// Self-checking bench for fb_clken_gen: expected strobe maps are built from the
// documented timing, queued per cycle, and popped as the DUT produces each cycle.
module tb_fb_clken_gen;

  logic        fclk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] div_in = 16'd0;
  logic [1:0]  div_load = 2'b00;
  logic        align = 1'b0;
  logic [1:0]  ce_out;
  logic        ready;

  typedef struct {
    int         t;
    logic [1:0] ce;
    logic       rdy;
  } exp_t;

  exp_t       sbq[$];
  exp_t       e;
  logic [1:0] expmap [0:599];
  int         cyc = -1;
  int         checks = 0;
  int         failures = 0;

  fb_clken_gen #(
    .NUM_CH(2), .DIV_W(8), .SETTLE_CYCLES(16), .DEFAULT_DIV(4)
  ) dut (
    .fclk(fclk), .rst(rst), .div_in(div_in), .div_load(div_load),
    .align(align), .ce_out(ce_out), .ready(ready)
  );

  always #5 fclk = ~fclk;

  task automatic step();
    @(posedge fclk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; div_load = 2'b00; align = 1'b0; div_in = 16'd0;
    step();
    step();
    rst = 1'b0;
    cyc = -1;
    for (int i = 0; i < 600; i++) expmap[i] = 2'b00;
  endtask

  function automatic void mark(input int ch, input int first, input int period, input int last);
    for (int t = first; t <= last; t += period) expmap[t][ch] = 1'b1;
  endfunction

  task automatic push_window(input int a, input int b);
    for (int t = a; t <= b; t++) sbq.push_back('{t, expmap[t], (t >= 16)});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++;
    if (ce_out !== 2'b00) begin failures++; $display("FAIL reset_ce got=%b exp=00", ce_out); end
  endtask

  task automatic test_default_and_load();
    do_reset();
    mark(0, 16, 4, 20); mark(0, 23, 3, 30);
    mark(1, 16, 4, 30);
    push_window(0, 30);
    while (cyc < 30) begin
      div_load = 2'b00; align = 1'b0;
      if (cyc == 17) begin div_load = 2'b01; div_in = {8'd0, 8'd3}; end
      step();
      if (sbq.size() > 0 && sbq[0].t == cyc) begin
        e = sbq.pop_front();
        checks++;
        if (ce_out !== e.ce) begin failures++; $display("FAIL load_ce cyc=%0d got=%b exp=%b", cyc, ce_out, e.ce); end
        checks++;
        if (ready !== e.rdy) begin failures++; $display("FAIL load_ready cyc=%0d got=%b exp=%b", cyc, ready, e.rdy); end
      end
    end
    checks++;
    if (sbq.size() != 0) begin failures++; $display("FAIL load_drain got=%0d exp=0", sbq.size()); sbq.delete(); end
  endtask

  task automatic test_align();
    do_reset();
    mark(0, 16, 4, 20); mark(0, 23, 3, 32); mark(0, 35, 3, 42);
    mark(1, 16, 4, 20); mark(1, 23, 4, 31); mark(1, 35, 2, 42);
    push_window(0, 42);
    while (cyc < 42) begin
      div_load = 2'b00; align = 1'b0;
      if (cyc == 7)  align = 1'b1;
      if (cyc == 17) begin div_load = 2'b01; div_in = {8'd0, 8'd3}; end
      if (cyc == 21) align = 1'b1;
      if (cyc == 33) begin align = 1'b1; div_load = 2'b10; div_in = {8'd2, 8'd0}; end
      step();
      if (sbq.size() > 0 && sbq[0].t == cyc) begin
        e = sbq.pop_front();
        checks++;
        if (ce_out !== e.ce) begin failures++; $display("FAIL align_ce cyc=%0d got=%b exp=%b", cyc, ce_out, e.ce); end
        checks++;
        if (ready !== e.rdy) begin failures++; $display("FAIL align_ready cyc=%0d got=%b exp=%b", cyc, ready, e.rdy); end
      end
    end
    checks++;
    if (sbq.size() != 0) begin failures++; $display("FAIL align_drain got=%0d exp=0", sbq.size()); sbq.delete(); end
  endtask

  task automatic test_settle_load();
    do_reset();
    mark(0, 16, 4, 32);
    mark(1, 16, 5, 32);
    push_window(0, 32);
    while (cyc < 32) begin
      div_load = 2'b00; align = 1'b0;
      if (cyc == 4) begin div_load = 2'b10; div_in = {8'd9, 8'd0}; end
      if (cyc == 6) begin div_load = 2'b10; div_in = {8'd5, 8'd0}; end
      if (cyc == 9) align = 1'b1;
      step();
      if (sbq.size() > 0 && sbq[0].t == cyc) begin
        e = sbq.pop_front();
        checks++;
        if (ce_out !== e.ce) begin failures++; $display("FAIL settle_ce cyc=%0d got=%b exp=%b", cyc, ce_out, e.ce); end
        checks++;
        if (ready !== e.rdy) begin failures++; $display("FAIL settle_ready cyc=%0d got=%b exp=%b", cyc, ready, e.rdy); end
      end
    end
    checks++;
    if (sbq.size() != 0) begin failures++; $display("FAIL settle_drain got=%0d exp=0", sbq.size()); sbq.delete(); end
  endtask

  task automatic test_ratio01();
    do_reset();
    mark(0, 16, 1, 16); mark(0, 20, 1, 30);
    mark(1, 16, 1, 16); mark(1, 20, 1, 30);
    push_window(0, 30);
    while (cyc < 30) begin
      div_load = 2'b00; align = 1'b0;
      if (cyc == 17) begin div_load = 2'b11; div_in = {8'd1, 8'd0}; end
      step();
      if (sbq.size() > 0 && sbq[0].t == cyc) begin
        e = sbq.pop_front();
        checks++;
        if (ce_out !== e.ce) begin failures++; $display("FAIL r01_ce cyc=%0d got=%b exp=%b", cyc, ce_out, e.ce); end
        checks++;
        if (ready !== e.rdy) begin failures++; $display("FAIL r01_ready cyc=%0d got=%b exp=%b", cyc, ready, e.rdy); end
      end
    end
    checks++;
    if (sbq.size() != 0) begin failures++; $display("FAIL r01_drain got=%0d exp=0", sbq.size()); sbq.delete(); end
  endtask

  task automatic test_ratio255_and_strobe_load();
    do_reset();
    mark(0, 16, 4, 20); mark(0, 275, 255, 535);
    mark(1, 16, 4, 24); mark(1, 30, 6, 535);
    push_window(0, 535);
    while (cyc < 535) begin
      div_load = 2'b00; align = 1'b0;
      if (cyc == 16) begin div_load = 2'b01; div_in = {8'd0, 8'd255}; end
      if (cyc == 23) begin div_load = 2'b10; div_in = {8'd6, 8'd0}; end
      step();
      if (sbq.size() > 0 && sbq[0].t == cyc) begin
        e = sbq.pop_front();
        checks++;
        if (ce_out !== e.ce) begin failures++; $display("FAIL r255_ce cyc=%0d got=%b exp=%b", cyc, ce_out, e.ce); end
        checks++;
        if (ready !== e.rdy) begin failures++; $display("FAIL r255_ready cyc=%0d got=%b exp=%b", cyc, ready, e.rdy); end
      end
    end
    checks++;
    if (sbq.size() != 0) begin failures++; $display("FAIL r255_drain got=%0d exp=0", sbq.size()); sbq.delete(); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    while (cyc < 40) begin
      div_load = 2'b00; align = 1'b0;
      if (cyc == 17) begin div_load = 2'b11; div_in = {8'd7, 8'd7}; end
      step();
    end
    rst = 1'b1;
    step();
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL rstmid_ready got=%b exp=0", ready); end
    checks++;
    if (ce_out !== 2'b00) begin failures++; $display("FAIL rstmid_ce got=%b exp=00", ce_out); end
    rst = 1'b0;
    cyc = -1;
    for (int i = 0; i < 600; i++) expmap[i] = 2'b00;
    mark(0, 16, 4, 28);
    mark(1, 16, 4, 28);
    push_window(0, 28);
    while (cyc < 28) begin
      step();
      if (sbq.size() > 0 && sbq[0].t == cyc) begin
        e = sbq.pop_front();
        checks++;
        if (ce_out !== e.ce) begin failures++; $display("FAIL rstmid_run_ce cyc=%0d got=%b exp=%b", cyc, ce_out, e.ce); end
        checks++;
        if (ready !== e.rdy) begin failures++; $display("FAIL rstmid_run_ready cyc=%0d got=%b exp=%b", cyc, ready, e.rdy); end
      end
    end
    checks++;
    if (sbq.size() != 0) begin failures++; $display("FAIL rstmid_drain got=%0d exp=0", sbq.size()); sbq.delete(); end
  endtask

  initial begin
    test_reset();
    test_default_and_load();
    test_align();
    test_settle_load();
    test_ratio01();
    test_ratio255_and_strobe_load();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_clken_gen.md
# fb_clken_gen

Parametrised clock-enable generator replacing per-design clock dividers on the fabric clock. From a single `fclk` it produces `NUM_CH` independent divide-by-D enable strobes and a `ready` flag that rises after a fixed settle interval following reset. Divide ratios load at run time and apply glitch-free at each channel's period boundary. It feeds the frame-buffer/DVI and core logic with enables instead of derived clocks.

## Interface
- `NUM_CH`, 2, number of enable channels
- `DIV_W`, 8, width of each divide ratio
- `SETTLE_CYCLES`, 16, cycles from reset release to `ready` (>=1)
- `DEFAULT_DIV`, 4, divide ratio of every channel at reset

- `fclk`  in  1  fabric clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `div_in`  in  NUM_CH*DIV_W  requested ratio per channel; channel i in bits [i*DIV_W +: DIV_W]
- `div_load`  in  NUM_CH  per-channel load strobe, one cycle
- `align`  in  1  restart all channel phases together
- `ce_out`  out  NUM_CH  per-channel enable strobe, registered
- `ready`  out  1  settle complete, enables valid, registered

## Operation
- States: SETTLE, RUN. `rst` forces SETTLE, settle counter 0, all channel counters 0, active ratios = shadow ratios = `DEFAULT_DIV`, `ready`=0, `ce_out`=0.
- SETTLE: counter increments each cycle; on reaching SETTLE_CYCLES-1, move to RUN. No `ce_out` pulses in SETTLE.
- RUN: `ready`=1 until next `rst`. Channel i with active ratio D asserts `ce_out[i]` for one cycle every D cycles; D=0 and D=1 both mean `ce_out[i]` held high.
- Per channel: down-counter loaded with D-1 at each strobe, strobe when it reaches 0.
- `div_load[i]` captures `div_in` slice into shadow register. Shadow copies to active only in the cycle `ce_out[i]` is asserted, so the period after that strobe uses the new D. Load coinciding with a strobe cycle: new value governs the immediately following period. Multiple loads within one period: last wins.
- Loads during SETTLE are accepted; the last one becomes the active ratio at RUN entry.
- `align` in RUN: all channel counters restart; every channel strobes in the next cycle, shadow ratios applied then. `align` in SETTLE: ignored. `align` and `div_load[i]` same cycle: the new ratio is applied at the aligned strobe.
- `rst` mid-operation: immediate return to reset values on the next edge, regardless of state.

## Timing
- Cycle 0 = first edge with `rst` sampled low. `ready` rises in cycle SETTLE_CYCLES. The first `ce_out` strobe on all channels is in cycle SETTLE_CYCLES (phase-aligned). The next strobes follow at +D.
- `align` sampled high in cycle t: every `ce_out` high in cycle t+1, then period D.
- `div_load` latency: 1 cycle to shadow; takes effect at the next strobe of that channel.
- Counter widths: DIV_W bits; D up to 2^DIV_W-1; no wrap beyond D-1.

## Structure
- Shared package `fb_clk_pkg`: state enum (SETTLE, RUN), `DIV_W` default, settle-counter width function (clog2 of SETTLE_CYCLES).
- One sub-module `fb_clken_ch`: single-channel shadow/active register, down-counter, strobe. Instantiated NUM_CH times under a generate loop. The top holds the settle FSM and `ready`.

## Test plan
- Reset release with defaults (NUM_CH=2, SETTLE_CYCLES=16, DEFAULT_DIV=4) -> `ready`=0 in cycles 0-15 and =1 from cycle 16. `ce_out`=2'b11 at cycles 16, 20, 24.
- `div_load`=2'b01 with ch0 ratio 3 in cycle 18 -> ch0 strobes at 20, 23, 26. ch1 stays at 24, 28.
- Ratio 0 and ratio 1 loaded -> channel `ce_out` constant 1 after its next strobe. Ratio 255 -> strobes 255 apart.
- `align` at cycle 22 with ch0 D=3, ch1 D=4 -> both strobe at 23. Then ch0 at 26 and ch1 at 27.
- `div_load` of ratio 5 in cycle 5, during SETTLE -> first strobe 16, next 21. `align` during SETTLE has no effect.
- `rst` asserted mid-RUN for one cycle -> next cycle `ready`=0, `ce_out`=0. The settle sequence restarts, and ratios return to 4.
